// File: rtl/vis_marker_pkg.sv
// Shared types and constants for the multi-channel marker overlay.
//   mode_e      : per-channel marker shape code
//   PIX_W       : RGB pixel width
//   DEF_COLORS  : default palette, channel 0 in the LSBs
package vis_marker_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_CROSS = 2'b01,
    MODE_BOX   = 2'b10,
    MODE_FILL  = 2'b11
  } mode_e;

  localparam logic [PIX_W-1:0] COL_RED = 24'hFF0000;
  localparam logic [PIX_W-1:0] COL_GRN = 24'h00FF00;
  localparam logic [PIX_W-1:0] COL_BLU = 24'h0000FF;
  localparam logic [PIX_W-1:0] COL_YEL = 24'hFFFF00;

  localparam logic [4*PIX_W-1:0] DEF_COLORS = {COL_YEL, COL_BLU, COL_GRN, COL_RED};

endpackage

// File: rtl/vis_marker_hit.sv
// One marker channel: distance from the channel centre and shape test,
// registered once (pipeline stage S2).
//   clk, rst : pixel clock, async active-high reset
//   x, y     : S1 pixel coordinate
//   xc, yc   : frame-latched centre of this channel
//   mode     : frame-latched shape
//   qual     : S1 de gated with frame lock
//   hit      : registered hit flag
module vis_marker_hit
  import vis_marker_pkg::*;
#(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 720,
  parameter int COORD_W  = 11,
  parameter int HALF_LEN = 8,
  parameter int THICK    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] xc,
  input  logic [COORD_W-1:0] yc,
  input  mode_e              mode,
  input  logic               qual,
  output logic               hit
);

  localparam int CW = COORD_W + 1;
  localparam logic [CW-1:0] HL   = CW'(HALF_LEN);
  localparam logic [CW-1:0] TK   = CW'(THICK);
  localparam logic [CW-1:0] EDGE = CW'(HALF_LEN - THICK);
  localparam logic [CW-1:0] XLIM = CW'(IMG_W);
  localparam logic [CW-1:0] YLIM = CW'(IMG_H);

  logic [CW-1:0] xe, ye, xce, yce, dx, dy;
  logic          in_rng, in_box, shape;

  assign xe  = {1'b0, x};
  assign ye  = {1'b0, y};
  assign xce = {1'b0, xc};
  assign yce = {1'b0, yc};

  // Absolute distance without modular wrap, so shapes clip at frame edges.
  assign dx = (xe >= xce) ? xe - xce : xce - xe;
  assign dy = (ye >= yce) ? ye - yce : yce - ye;

  // A centre outside the active area disables the channel for the frame.
  assign in_rng = (xce < XLIM) && (yce < YLIM);
  assign in_box = (dx <= HL) && (dy <= HL);

  always_comb begin
    shape = 1'b0;
    case (mode)
      MODE_CROSS: shape = ((dx <= TK) && (dy <= HL)) || ((dy <= TK) && (dx <= HL));
      MODE_BOX:   shape = in_box && ((dx >= EDGE) || (dy >= EDGE));
      MODE_FILL:  shape = in_box;
      default:    shape = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit <= 1'b0;
    else     hit <= qual & in_rng & shape;
  end

endmodule

// File: rtl/vis_marker_multi.sv
// Inline overlay of up to N_MARK markers on a 24-bit HDMI-timed stream.
// Fixed 3-cycle latency: S1 input/coordinate register, S2 per-channel hit,
// S3 priority colour mux. Marker positions and modes are latched on the
// vsync rising edge and hold for the whole frame.
//   clk, rst            : pixel clock, async active-high reset
//   de, hsync, vsync    : input timing
//   pixel_in            : {R,G,B}
//   x_center, y_center  : per-channel centre, channel 0 in LSBs
//   mode                : per-channel 2-bit shape code
//   de_out, hsync_out, vsync_out, pixel_out : delayed/overlaid stream
//   mark_hit            : per-channel hit flags aligned with pixel_out
module vis_marker_multi
  import vis_marker_pkg::*;
#(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 720,
  parameter int N_MARK   = 4,
  parameter int COORD_W  = 11,
  parameter int HALF_LEN = 8,
  parameter int THICK    = 1,
  parameter logic [N_MARK*PIX_W-1:0] MARK_COLORS = DEF_COLORS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [PIX_W-1:0]          pixel_in,
  input  logic [N_MARK*COORD_W-1:0] x_center,
  input  logic [N_MARK*COORD_W-1:0] y_center,
  input  logic [N_MARK*2-1:0]       mode,
  output logic                      de_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [PIX_W-1:0]          pixel_out,
  output logic [N_MARK-1:0]         mark_hit
);

  localparam int STAGES = 3;
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);

  logic [STAGES:1]                  vld_pipe, hs_pipe, vs_pipe;
  logic [2:1][PIX_W-1:0]            pix_pipe;
  logic [COORD_W-1:0]               x_cnt, y_cnt, s1_x, s1_y;
  logic                             locked;
  logic [N_MARK-1:0][COORD_W-1:0]   xc_sh, yc_sh;
  logic [N_MARK-1:0][1:0]           mode_sh;
  logic [N_MARK-1:0][PIX_W-1:0]     colors;
  logic [N_MARK-1:0]                hit_s2;
  logic [PIX_W-1:0]                 pix_mux;
  logic                             de_fall, vs_rise, qual_s1;

  assign colors  = MARK_COLORS;
  // Stage-1 copies double as the previous-cycle value for edge detection.
  assign de_fall = vld_pipe[1] & ~de;
  assign vs_rise = vsync & ~vs_pipe[1];
  assign qual_s1 = vld_pipe[1] & locked;

  // Raster counters and per-frame shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      locked  <= 1'b0;
      xc_sh   <= '0;
      yc_sh   <= '0;
      mode_sh <= '0;
    end else if (vs_rise) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      locked  <= 1'b1;
      xc_sh   <= x_center;
      yc_sh   <= y_center;
      mode_sh <= mode;
    end else if (de) begin
      x_cnt <= x_cnt + 1'b1;
    end else if (de_fall) begin
      x_cnt <= '0;
      if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
    end
  end

  // Timing/data delay lines and S1 coordinate capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      pix_pipe <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], de};
      hs_pipe     <= {hs_pipe[STAGES-1:1], hsync};
      vs_pipe     <= {vs_pipe[STAGES-1:1], vsync};
      pix_pipe[1] <= pixel_in;
      pix_pipe[2] <= pix_pipe[1];
      s1_x        <= x_cnt;
      s1_y        <= y_cnt;
    end
  end

  for (genvar gi = 0; gi < N_MARK; gi++) begin : g_ch
    vis_marker_hit #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .COORD_W  (COORD_W),
      .HALF_LEN (HALF_LEN),
      .THICK    (THICK)
    ) u_hit (
      .clk  (clk),
      .rst  (rst),
      .x    (s1_x),
      .y    (s1_y),
      .xc   (xc_sh[gi]),
      .yc   (yc_sh[gi]),
      .mode (mode_e'(mode_sh[gi])),
      .qual (qual_s1),
      .hit  (hit_s2[gi])
    );
  end

  // Walk from the highest channel down so the lowest hitting index wins.
  always_comb begin
    pix_mux = pix_pipe[2];
    for (int i = N_MARK - 1; i >= 0; i--)
      if (hit_s2[i]) pix_mux = colors[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out <= '0;
      mark_hit  <= '0;
    end else begin
      pixel_out <= pix_mux;
      mark_hit  <= hit_s2;
    end
  end

  assign de_out    = vld_pipe[STAGES];
  assign hsync_out = hs_pipe[STAGES];
  assign vsync_out = vs_pipe[STAGES];

endmodule

// File: tb/tb_vis_marker_multi.sv
// Directed bench for vis_marker_multi: drives short-line frames, captures
// the output raster by output-side coordinates and checks hand-picked pixels.
module tb_vis_marker_multi;

  localparam int NM = 4;
  localparam int CW = 11;

  logic             clk = 1'b0, rst = 1'b0, de = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [23:0]      pixel_in = '0;
  logic [NM*CW-1:0] x_center = '0, y_center = '0;
  logic [NM*2-1:0]  mode = '0;
  logic             de_out, hsync_out, vsync_out;
  logic [23:0]      pixel_out;
  logic [NM-1:0]    mark_hit;

  int total = 0, bad = 0;
  int pt_err = 0, hit_cnt = 0, pt_base = 0, hit_base = 0;
  logic pt_chk = 1'b0;
  logic [23:0] cap_pix [int];
  logic [3:0]  cap_hit [int];

  localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;

  vis_marker_multi u_dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
    .pixel_in(pixel_in), .x_center(x_center), .y_center(y_center), .mode(mode),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .pixel_out(pixel_out), .mark_hit(mark_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x; yv = y;
    return {8'h5A, yv[7:0], xv[7:0]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int ch, input int x, input int y, input int m);
    logic [31:0] xv, yv, mv;
    xv = x; yv = y; mv = m;
    x_center[ch*CW +: CW] = xv[CW-1:0];
    y_center[ch*CW +: CW] = yv[CW-1:0];
    mode[ch*2 +: 2]       = mv[1:0];
  endtask

  task automatic chk_px(input int x, input int y, input logic [23:0] ep, input logic [3:0] eh);
    int k;
    logic [23:0] gp;
    logic [3:0]  gh;
    k = y * 4096 + x;
    if (cap_pix.exists(k)) begin gp = cap_pix[k]; gh = cap_hit[k]; end
    else begin gp = 'x; gh = 'x; end
    chk($sformatf("pix(%0d,%0d)", x, y), {8'h0, gp}, {8'h0, ep});
    chk($sformatf("hit(%0d,%0d)", x, y), {28'h0, gh}, {28'h0, eh});
  endtask

  // chg_ln: line at which ch0 x_center moves to 200; rst_ln: line hit by reset.
  task automatic drive_frame(input int nl, input int w, input int w0,
                             input int chg_ln, input int rst_ln);
    de = 1'b0; pixel_in = '0; hsync = 1'b0; vsync = 1'b1;
    repeat (2) step();
    vsync = 1'b0;
    repeat (2) step();
    for (int ln = 0; ln < nl; ln++) begin
      int wl;
      wl = (ln == 0) ? w0 : w;
      if (ln == chg_ln) x_center[CW-1:0] = 11'd200;
      for (int x = 0; x < wl; x++) begin
        de = 1'b1; pixel_in = pat(x, ln);
        step();
        if (ln == rst_ln && x == 3) begin
          de = 1'b0; pixel_in = '0; rst = 1'b1;
          #1;
          chk("rst_mid_out", {1'b0, de_out, hsync_out, vsync_out, pixel_out, mark_hit}, 32'h0);
          step();
          rst = 1'b0;
          repeat (4) step();
          pt_base = pt_err; hit_base = hit_cnt; pt_chk = 1'b1;
          break;
        end
      end
      de = 1'b0; pixel_in = '0;
      step();
      hsync = 1'b1; step();
      hsync = 1'b0; step();
    end
    repeat (5) step();
  endtask

  // Output monitor: output-side raster position plus a 3-deep input history
  // for pass-through comparison.
  initial begin
    int ox, oy;
    logic mde, mvs;
    logic [26:0] h0, h1, h2, h3;
    ox = 0; oy = 0; mde = 1'b0; mvs = 1'b0;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    forever begin
      @(negedge clk);
      if (vsync_out && !mvs) begin ox = 0; oy = 0; end
      if (de_out) begin
        cap_pix[oy * 4096 + ox] = pixel_out;
        cap_hit[oy * 4096 + ox] = mark_hit;
        ox++;
      end else if (mde) begin
        ox = 0; oy++;
      end
      if (mark_hit != '0) hit_cnt++;
      mvs = vsync_out; mde = de_out;
      h3 = h2; h2 = h1; h1 = h0; h0 = {de, hsync, vsync, pixel_in};
      if (pt_chk && ({de_out, hsync_out, vsync_out, pixel_out} !== h3)) pt_err++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1; step(); step();
    chk("rst_out", {1'b0, de_out, hsync_out, vsync_out, pixel_out, mark_hit}, 32'h0);
    rst = 1'b0; step();

    // Latency: one de pixel before any vsync passes through unmarked
    de = 1'b1; pixel_in = 24'h123456; step();
    de = 1'b0; pixel_in = '0;
    chk("lat1_de", de_out, 0); step();
    chk("lat2_de", de_out, 0); step();
    chk("lat3_de", de_out, 1);
    chk("lat3_px", pixel_out, 24'h123456);
    chk("lat3_hit", mark_hit, 0);
    step();
    chk("lat4_de", de_out, 0);

    // Cross at (28,37); ch0 x moves to 200 at line 5 (takes effect next frame)
    set_ch(0, 28, 37, 1);
    drive_frame(48, 48, 48, 5, -1);
    for (int y = 29; y <= 45; y++)
      for (int x = 27; x <= 29; x++) chk_px(x, y, RED, 4'b0001);
    for (int y = 36; y <= 38; y++)
      for (int x = 20; x <= 36; x++) chk_px(x, y, RED, 4'b0001);
    chk_px(31, 31, pat(31, 31), 4'b0000);
    chk_px(19, 37, pat(19, 37), 4'b0000);
    chk_px(28, 46, pat(28, 46), 4'b0000);

    drive_frame(40, 210, 210, -1, -1);
    chk_px(200, 37, RED, 4'b0001);
    chk_px(200, 29, RED, 4'b0001);
    chk_px(28, 37, pat(28, 37), 4'b0000);

    // Overlap priority, box outline, off channel
    set_ch(0, 100, 100, 3);
    set_ch(1, 104, 100, 1);
    set_ch(2, 40, 40, 2);
    set_ch(3, 60, 60, 0);
    drive_frame(102, 112, 112, -1, -1);
    chk_px(104, 100, RED, 4'b0011);
    chk_px(110, 100, GRN, 4'b0010);
    chk_px(108, 100, RED, 4'b0011);
    chk_px(100, 95, RED, 4'b0001);
    chk_px(32, 40, BLU, 4'b0100);
    chk_px(34, 40, pat(34, 40), 4'b0000);
    chk_px(33, 45, BLU, 4'b0100);
    chk_px(40, 48, BLU, 4'b0100);
    chk_px(40, 40, pat(40, 40), 4'b0000);
    chk_px(49, 40, pat(49, 40), 4'b0000);
    chk_px(60, 60, pat(60, 60), 4'b0000);

    // Edges: corner fill, bottom cross with y saturation, y out of range
    set_ch(0, 0, 0, 3);
    set_ch(1, 9, 719, 1);
    set_ch(2, 3, 720, 3);
    set_ch(3, 0, 0, 0);
    drive_frame(724, 10, 1280, -1, -1);
    chk_px(0, 0, RED, 4'b0001);
    chk_px(8, 8, RED, 4'b0001);
    chk_px(8, 0, RED, 4'b0001);
    chk_px(0, 8, RED, 4'b0001);
    chk_px(9, 0, pat(9, 0), 4'b0000);
    chk_px(0, 9, pat(0, 9), 4'b0000);
    chk_px(1279, 0, pat(1279, 0), 4'b0000);
    chk_px(1278, 0, pat(1278, 0), 4'b0000);
    chk_px(0, 719, pat(0, 719), 4'b0000);
    chk_px(1, 719, GRN, 4'b0010);
    chk_px(1, 718, GRN, 4'b0010);
    chk_px(1, 717, pat(1, 717), 4'b0000);
    chk_px(9, 712, GRN, 4'b0010);
    chk_px(9, 710, pat(9, 710), 4'b0000);
    chk_px(3, 714, pat(3, 714), 4'b0000);
    chk_px(0, 720, pat(0, 720), 4'b0000);
    chk_px(1, 723, GRN, 4'b0010);

    // x out of range: whole frame passes through untouched
    set_ch(0, 1300, 2, 3);
    set_ch(1, 0, 0, 0);
    set_ch(2, 0, 0, 0);
    pt_base = pt_err; hit_base = hit_cnt; pt_chk = 1'b1;
    drive_frame(5, 1310, 1310, -1, -1);
    pt_chk = 1'b0;
    chk("oor_passthru_errs", pt_err - pt_base, 0);
    chk("oor_hit_cycles", hit_cnt - hit_base, 0);

    // Reset mid-frame at line 300, then recovery on next frame
    set_ch(0, 3, 3, 3);
    drive_frame(310, 8, 8, -1, 300);
    pt_chk = 1'b0;
    chk("rst_passthru_errs", pt_err - pt_base, 0);
    chk("rst_hit_cycles", hit_cnt - hit_base, 0);
    chk_px(3, 3, RED, 4'b0001);
    drive_frame(8, 8, 8, -1, -1);
    chk_px(3, 3, RED, 4'b0001);
    chk_px(0, 0, RED, 4'b0001);
    chk_px(7, 7, RED, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
